ddr_arbiter: RTL and testbench
==============================

DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter AddrWidth, default 24, client/controller word address width (2 bank + 13 row + 9 column).
REQ-002 SHALL have parameter DataWidth, default 32, client word width (two 16-bit DDR beats).
REQ-003 SHALL have parameter RefreshPeriod, default 390, clock cycles between refresh requests (7.8 us at 50 MHz).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have these ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- c0_req, c1_req  in  1  client request, held until ack
- c0_write, c1_write  in  1  1 = write, 0 = read
- c0_addr, c1_addr  in  AddrWidth  word address
- c0_wdata, c1_wdata  in  DataWidth  write data
- c0_ack, c1_ack  out  1  one-cycle completion pulse
- rdata  out  DataWidth  read data, valid with the ack
- mc_cmd_valid  out  1  command offered to the controller
- mc_cmd_ready  in  1  controller accepts the command
- mc_cmd  out  2  0 = NOP, 1 = READ, 2 = WRITE, 3 = REFRESH
- mc_addr  out  AddrWidth  command address
- mc_wdata  out  DataWidth  command write data
- mc_done  in  1  one-cycle pulse: accepted command complete
- mc_rdata  in  DataWidth  read data, valid with mc_done
- refresh_overrun  out  1  sticky refresh-missed flag

Function
REQ-006 SHALL implement states IDLE, ISSUE, WAIT.
REQ-007 In IDLE SHALL select, in priority order: pending refresh; otherwise the client not granted last (round robin); otherwise the single requesting client.
REQ-008 On a selection in IDLE SHALL latch mc_cmd, mc_addr, mc_wdata and the grant owner, and go to ISSUE; mc_cmd_valid is high the next cycle.
REQ-009 In ISSUE SHALL hold mc_cmd_valid and the latched fields stable until the cycle mc_cmd_ready=1, then go to WAIT.
REQ-010 In WAIT SHALL drive mc_cmd_valid=0 and mc_cmd=NOP, and ignore mc_done unless in WAIT.
REQ-011 On mc_done in WAIT SHALL return to IDLE; for a client command pulse that client's ack for exactly one cycle (the next cycle) with rdata = mc_rdata registered on that mc_done (hold previous value on writes).
REQ-012 For a REFRESH command SHALL clear refresh-pending on mc_done and pulse no ack.
REQ-013 SHALL update the round-robin pointer only when a client command completes.
REQ-014 Refresh counter SHALL count down from RefreshPeriod-1 and, at 0, reload and set refresh-pending.
REQ-015 If refresh-pending is already set when the counter reaches 0, SHALL set refresh_overrun, held until reset.
REQ-016 Changes on client inputs after a grant SHALL not affect the latched command.
REQ-017 A client that drops its request before being granted SHALL receive no ack.
REQ-018 A counter expiry in the same cycle as the mc_done of a refresh SHALL leave refresh-pending set.
REQ-019 Minimum IDLE dwell SHALL be one cycle between commands.

Reset
REQ-020 Reset SHALL force state IDLE and refresh counter = RefreshPeriod-1, and clear refresh-pending, the round-robin pointer (client 0 first), mc_cmd_valid, mc_cmd (NOP), mc_addr, mc_wdata, rdata, c0_ack, c1_ack and refresh_overrun to 0.
REQ-021 Reset mid-command SHALL abandon the command with no ack; the controller's own reset handles its side.

Structure
REQ-022 mc_cmd encodings and state encodings SHALL live in a shared package, ddr_pkg.
REQ-023 The refresh timer SHALL be a sub-module, ddr_refresh_timer, with outputs tick and overrun.

Verification
REQ-024 Bench SHALL cover:
- c0 read addr 0x000100, mc_cmd_ready tied 1, mc_done 3 cycles later with mc_rdata 0xDEADBEEF -> one c0_ack with rdata 0xDEADBEEF, mc_cmd=READ seen once.
- c0 and c1 request simultaneously, repeatedly -> grants alternate c0, c1, c0, c1.
- Refresh pending and c1 requesting at IDLE -> REFRESH issued first, then c1; no ack for the refresh.
- mc_cmd_ready held 0 for 5 cycles -> mc_cmd_valid, mc_addr and mc_wdata stable across all 5.
- mc_cmd_ready held 0 for 2*RefreshPeriod cycles -> refresh_overrun=1 and stays 1 until reset.
- Reset asserted in WAIT -> all outputs 0 and state IDLE; a later mc_done produces no ack.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared encodings for the DDR arbiter: controller command codes and arbiter FSM states.
package ddr_pkg;

   typedef enum logic [1:0] {
      CmdNop     = 2'd0,
      CmdRead    = 2'd1,
      CmdWrite   = 2'd2,
      CmdRefresh = 2'd3
   } ddr_cmd_e;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StIssue = 2'd1;
   localparam logic [1:0] StWait  = 2'd2;

   function automatic logic [1:0] client_cmd(input logic write);
      return write ? CmdWrite : CmdRead;
   endfunction

endpackage

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh interval timer: ticks every RefreshPeriod cycles and flags a tick that
// lands while the previous refresh is still pending.
module ddr_refresh_timer #(
   parameter int unsigned RefreshPeriod = 390
) (
   input  logic clock,
   input  logic reset,
   input  logic pending,
   output logic tick,
   output logic overrun
);

   localparam int unsigned CntW = (RefreshPeriod > 1) ? $clog2(RefreshPeriod) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(RefreshPeriod - 1);

   logic [CntW-1:0] r_count;
   logic            r_overrun;

   assign tick    = (r_count == '0);
   assign overrun = r_overrun;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count   <= Reload;
         r_overrun <= 1'b0;
      end else begin
         r_count <= tick ? Reload : r_count - 1'b1;
         if (tick && pending) begin
            r_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr_arbiter.sv
// Two-client round-robin arbiter in front of a DDR controller, with periodic refresh insertion
// taking priority over client traffic.
module ddr_arbiter
   import ddr_pkg::*;
#(
   parameter int unsigned AddrWidth     = 24,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned RefreshPeriod = 390
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 c0_req,
   input  logic                 c1_req,
   input  logic                 c0_write,
   input  logic                 c1_write,
   input  logic [AddrWidth-1:0] c0_addr,
   input  logic [AddrWidth-1:0] c1_addr,
   input  logic [DataWidth-1:0] c0_wdata,
   input  logic [DataWidth-1:0] c1_wdata,
   output logic                 c0_ack,
   output logic                 c1_ack,
   output logic [DataWidth-1:0] rdata,
   output logic                 mc_cmd_valid,
   input  logic                 mc_cmd_ready,
   output logic [1:0]           mc_cmd,
   output logic [AddrWidth-1:0] mc_addr,
   output logic [DataWidth-1:0] mc_wdata,
   input  logic                 mc_done,
   input  logic [DataWidth-1:0] mc_rdata,
   output logic                 refresh_overrun
);

   logic [1:0]           r_state;
   logic                 r_owner;
   logic                 r_rr_next;
   logic                 r_refresh_cmd;
   logic                 r_is_read;
   logic                 r_pending;
   logic                 r_mc_cmd_valid;
   logic [1:0]           r_mc_cmd;
   logic [AddrWidth-1:0] r_mc_addr;
   logic [DataWidth-1:0] r_mc_wdata;
   logic [DataWidth-1:0] r_rdata;
   logic                 r_c0_ack;
   logic                 r_c1_ack;

   logic                 w_tick;
   logic                 w_overrun;
   logic                 w_c0_elig;
   logic                 w_c1_elig;
   logic                 w_pick_c1;
   logic                 w_client_sel;
   logic                 w_sel_write;
   logic [AddrWidth-1:0] w_sel_addr;
   logic [DataWidth-1:0] w_sel_wdata;
   logic                 w_done;

   ddr_refresh_timer #(
      .RefreshPeriod(RefreshPeriod)
   ) u_refresh_timer (
      .clock  (clock),
      .reset  (reset),
      .pending(r_pending),
      .tick   (w_tick),
      .overrun(w_overrun)
   );

   // A client whose ack is showing this cycle has not yet had a chance to drop its request.
   assign w_c0_elig    = c0_req & ~r_c0_ack;
   assign w_c1_elig    = c1_req & ~r_c1_ack;
   assign w_pick_c1    = w_c1_elig & (~w_c0_elig | r_rr_next);
   assign w_client_sel = w_c0_elig | w_c1_elig;
   assign w_sel_write  = w_pick_c1 ? c1_write : c0_write;
   assign w_sel_addr   = w_pick_c1 ? c1_addr  : c0_addr;
   assign w_sel_wdata  = w_pick_c1 ? c1_wdata : c0_wdata;
   assign w_done       = (r_state == StWait) & mc_done;

   // A timer tick wins over the completion of the refresh it would otherwise clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pending <= 1'b0;
      end else if (w_tick) begin
         r_pending <= 1'b1;
      end else if (w_done && r_refresh_cmd) begin
         r_pending <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= StIdle;
         r_owner        <= 1'b0;
         r_rr_next      <= 1'b0;
         r_refresh_cmd  <= 1'b0;
         r_is_read      <= 1'b0;
         r_mc_cmd_valid <= 1'b0;
         r_mc_cmd       <= CmdNop;
         r_mc_addr      <= '0;
         r_mc_wdata     <= '0;
         r_rdata        <= '0;
         r_c0_ack       <= 1'b0;
         r_c1_ack       <= 1'b0;
      end else begin
         r_c0_ack <= 1'b0;
         r_c1_ack <= 1'b0;
         case (r_state)
            StIdle: begin
               if (r_pending) begin
                  r_state        <= StIssue;
                  r_refresh_cmd  <= 1'b1;
                  r_is_read      <= 1'b0;
                  r_mc_cmd_valid <= 1'b1;
                  r_mc_cmd       <= CmdRefresh;
                  r_mc_addr      <= '0;
                  r_mc_wdata     <= '0;
               end else if (w_client_sel) begin
                  r_state        <= StIssue;
                  r_owner        <= w_pick_c1;
                  r_refresh_cmd  <= 1'b0;
                  r_is_read      <= ~w_sel_write;
                  r_mc_cmd_valid <= 1'b1;
                  r_mc_cmd       <= client_cmd(w_sel_write);
                  r_mc_addr      <= w_sel_addr;
                  r_mc_wdata     <= w_sel_wdata;
               end
            end
            StIssue: begin
               if (mc_cmd_ready) begin
                  r_state        <= StWait;
                  r_mc_cmd_valid <= 1'b0;
                  r_mc_cmd       <= CmdNop;
               end
            end
            StWait: begin
               if (mc_done) begin
                  r_state <= StIdle;
                  if (!r_refresh_cmd) begin
                     r_c0_ack  <= ~r_owner;
                     r_c1_ack  <= r_owner;
                     r_rr_next <= ~r_owner;
                     if (r_is_read) begin
                        r_rdata <= mc_rdata;
                     end
                  end
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign c0_ack          = r_c0_ack;
   assign c1_ack          = r_c1_ack;
   assign rdata           = r_rdata;
   assign mc_cmd_valid    = r_mc_cmd_valid;
   assign mc_cmd          = r_mc_cmd;
   assign mc_addr         = r_mc_addr;
   assign mc_wdata        = r_mc_wdata;
   assign refresh_overrun = w_overrun;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Randomised and directed bench for ddr_arbiter, checked every cycle against a transaction-level
// model of the arbitration, refresh and handshake rules.
module tb_ddr_arbiter;

   localparam int AW = 24;
   localparam int DW = 32;
   localparam int P  = 40;

   localparam logic [1:0] NOP = 2'd0;
   localparam logic [1:0] RD  = 2'd1;
   localparam logic [1:0] WR  = 2'd2;
   localparam logic [1:0] RF  = 2'd3;

   logic          clock;
   logic          reset;
   logic [1:0]    creq;
   logic [1:0]    cwrite;
   logic [AW-1:0] caddr [2];
   logic [DW-1:0] cwdata [2];
   logic [1:0]    cack;
   logic [DW-1:0] rdata;
   logic          mc_cmd_valid;
   logic          mc_cmd_ready;
   logic [1:0]    mc_cmd;
   logic [AW-1:0] mc_addr;
   logic [DW-1:0] mc_wdata;
   logic          mc_done;
   logic [DW-1:0] mc_rdata;
   logic          refresh_overrun;

   ddr_arbiter #(
      .AddrWidth    (AW),
      .DataWidth    (DW),
      .RefreshPeriod(P)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .c0_req         (creq[0]),
      .c1_req         (creq[1]),
      .c0_write       (cwrite[0]),
      .c1_write       (cwrite[1]),
      .c0_addr        (caddr[0]),
      .c1_addr        (caddr[1]),
      .c0_wdata       (cwdata[0]),
      .c1_wdata       (cwdata[1]),
      .c0_ack         (cack[0]),
      .c1_ack         (cack[1]),
      .rdata          (rdata),
      .mc_cmd_valid   (mc_cmd_valid),
      .mc_cmd_ready   (mc_cmd_ready),
      .mc_cmd         (mc_cmd),
      .mc_addr        (mc_addr),
      .mc_wdata       (mc_wdata),
      .mc_done        (mc_done),
      .mc_rdata       (mc_rdata),
      .refresh_overrun(refresh_overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 = free, 1 = command offered, 2 = command accepted, awaiting done.
   int            m_phase;
   int            m_owner;  // 0/1 = client, 2 = refresh
   logic [1:0]    m_cmd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   bit            m_pending;
   bit            m_overrun;
   bit            m_rr;
   int            m_cyc;
   bit            e_valid;
   logic [1:0]    e_cmd;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata;
   bit [1:0]      e_ack;
   logic [DW-1:0] e_rdata;
   bit            e_overrun;

   // Bench-side controller and client knobs.
   bit            ctl_out;
   int            ctl_cnt;
   int            ready_mode;
   int            done_delay;
   bit            spurious_en;
   bit            rand_clients;
   bit            rdata_fixed;
   logic [DW-1:0] rdata_val;

   int            ack_q [$];
   logic [1:0]    cmd_q [$];
   logic [AW-1:0] addr_q [$];

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_phase   = 0;
      m_owner   = 0;
      m_cmd     = NOP;
      m_addr    = '0;
      m_wdata   = '0;
      m_pending = 1'b0;
      m_overrun = 1'b0;
      m_rr      = 1'b0;
      m_cyc     = 0;
      e_valid   = 1'b0;
      e_cmd     = NOP;
      e_addr    = '0;
      e_wdata   = '0;
      e_ack     = '0;
      e_rdata   = '0;
      e_overrun = 1'b0;
   endfunction

   // Advances the model by one clock edge using the inputs the DUT is about to sample.
   function automatic void model_step();
      bit       tick;
      bit       rq0;
      bit       rq1;
      int       who;
      bit [1:0] nack;
      tick = (m_cyc % P) == P - 1;
      m_cyc++;
      rq0  = creq[0] && !e_ack[0];
      rq1  = creq[1] && !e_ack[1];
      nack = '0;
      if (tick && m_pending) m_overrun = 1'b1;
      case (m_phase)
         0: begin
            if (m_pending) begin
               m_owner = 2;
               m_cmd   = RF;
               m_addr  = '0;
               m_wdata = '0;
               m_phase = 1;
            end else if (rq0 || rq1) begin
               who     = (rq0 && rq1) ? int'(m_rr) : (rq1 ? 1 : 0);
               m_owner = who;
               m_cmd   = cwrite[who] ? WR : RD;
               m_addr  = caddr[who];
               m_wdata = cwdata[who];
               m_phase = 1;
            end
         end
         1: if (mc_cmd_ready) m_phase = 2;
         default: begin
            if (mc_done) begin
               m_phase = 0;
               if (m_owner == 2) begin
                  m_pending = 1'b0;
               end else begin
                  nack[m_owner] = 1'b1;
                  m_rr          = (m_owner == 0);
                  if (m_cmd == RD) e_rdata = mc_rdata;
               end
            end
         end
      endcase
      if (tick) m_pending = 1'b1;
      e_ack     = nack;
      e_valid   = (m_phase == 1);
      e_cmd     = e_valid ? m_cmd : NOP;
      e_addr    = m_addr;
      e_wdata   = m_wdata;
      e_overrun = m_overrun;
   endfunction

   function automatic void compare_all();
      chk("mc_cmd_valid", mc_cmd_valid, e_valid);
      chk("mc_cmd", mc_cmd, e_cmd);
      chk("mc_addr", mc_addr, e_addr);
      chk("mc_wdata", mc_wdata, e_wdata);
      chk("c0_ack", cack[0], e_ack[0]);
      chk("c1_ack", cack[1], e_ack[1]);
      chk("rdata", rdata, e_rdata);
      chk("refresh_overrun", refresh_overrun, e_overrun);
   endfunction

   task automatic drive_clients();
      for (int i = 0; i < 2; i++) begin
         if (!creq[i]) begin
            if ($urandom_range(3) == 0) begin
               creq[i]   = 1'b1;
               cwrite[i] = 1'($urandom);
               caddr[i]  = AW'($urandom);
               cwdata[i] = $urandom;
            end
         end else begin
            int r;
            r = int'($urandom_range(31));
            if (r == 0) begin
               creq[i] = 1'b0;
            end else if (r < 5) begin
               cwrite[i] = 1'($urandom);
               caddr[i]  = AW'($urandom);
               cwdata[i] = $urandom;
            end
         end
      end
   endtask

   task automatic cycle();
      bit accept;
      mc_done  = 1'b0;
      mc_rdata = rdata_fixed ? rdata_val : $urandom;
      if (ctl_out) begin
         if (ctl_cnt <= 1) mc_done = 1'b1;
         else ctl_cnt--;
      end else if (spurious_en && $urandom_range(9) == 0) begin
         mc_done = 1'b1;
      end
      case (ready_mode)
         0:       mc_cmd_ready = 1'b0;
         1:       mc_cmd_ready = 1'b1;
         default: mc_cmd_ready = ($urandom_range(2) != 0);
      endcase
      accept = mc_cmd_valid && mc_cmd_ready;
      if (accept) begin
         cmd_q.push_back(mc_cmd);
         addr_q.push_back(mc_addr);
      end
      model_step();
      @(posedge clock);
      #1;
      if (ctl_out && mc_done) ctl_out = 1'b0;
      if (accept) begin
         ctl_out = 1'b1;
         ctl_cnt = (done_delay != 0) ? done_delay : int'($urandom_range(4, 1));
      end
      compare_all();
      for (int i = 0; i < 2; i++) begin
         if (cack[i]) begin
            ack_q.push_back(i);
            creq[i] = 1'b0;
         end
      end
      if (rand_clients) drive_clients();
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      creq         = '0;
      mc_done      = 1'b0;
      mc_cmd_ready = 1'b0;
      ctl_out      = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", mc_cmd_valid, 0);
      chk("rst_cmd", mc_cmd, NOP);
      chk("rst_addr", mc_addr, 0);
      chk("rst_wdata", mc_wdata, 0);
      chk("rst_acks", cack, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_overrun", refresh_overrun, 0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic clear_logs();
      ack_q.delete();
      cmd_q.delete();
      addr_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish, expected finish before time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int nreads;
      reset        = 1'b1;
      creq         = '0;
      cwrite       = '0;
      caddr[0]     = '0;
      caddr[1]     = '0;
      cwdata[0]    = '0;
      cwdata[1]    = '0;
      mc_cmd_ready = 1'b0;
      mc_done      = 1'b0;
      mc_rdata     = '0;
      ready_mode   = 1;
      done_delay   = 1;
      spurious_en  = 1'b0;
      rand_clients = 1'b0;
      rdata_fixed  = 1'b0;
      rdata_val    = '0;
      ctl_out      = 1'b0;
      ctl_cnt      = 0;

      // Single c0 read completing three cycles after acceptance.
      do_reset();
      clear_logs();
      ready_mode  = 1;
      done_delay  = 3;
      rdata_fixed = 1'b1;
      rdata_val   = 32'hDEADBEEF;
      cwrite[0]   = 1'b0;
      caddr[0]    = 24'h000100;
      creq[0]     = 1'b1;
      repeat (12) cycle();
      nreads = 0;
      foreach (cmd_q[k]) if (cmd_q[k] == RD) nreads++;
      chk("t1_ack_count", ack_q.size(), 1);
      chk("t1_ack_owner", (ack_q.size() > 0) ? ack_q[0] : -1, 0);
      chk("t1_rdata", rdata, 32'hDEADBEEF);
      chk("t1_read_cmds", nreads, 1);
      chk("t1_addr", (addr_q.size() > 0) ? addr_q[0] : '1, 24'h000100);
      rdata_fixed = 1'b0;

      // Both clients requesting continuously must alternate, c0 first.
      do_reset();
      clear_logs();
      done_delay = 1;
      cwrite     = 2'b01;
      caddr[0]   = 24'h000010;
      caddr[1]   = 24'h000020;
      creq       = 2'b11;
      for (int i = 0; i < 200 && ack_q.size() < 8; i++) begin
         cycle();
         if (!creq[0]) creq[0] = 1'b1;
         if (!creq[1]) creq[1] = 1'b1;
      end
      creq = '0;
      repeat (4) cycle();
      chk("t2_ack_count", ack_q.size() >= 8, 1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t2_grant%0d", k), (k < ack_q.size()) ? ack_q[k] : -1, k % 2);
      end

      // Refresh pending and c1 requesting together: refresh goes first, no ack for it.
      do_reset();
      clear_logs();
      done_delay = 2;
      repeat (P) cycle();
      cwrite[1] = 1'b1;
      caddr[1]  = 24'h0ABCDE;
      cwdata[1] = 32'h12345678;
      creq[1]   = 1'b1;
      repeat (15) cycle();
      chk("t3_first_cmd", (cmd_q.size() > 0) ? cmd_q[0] : 2'bx, RF);
      chk("t3_second_cmd", (cmd_q.size() > 1) ? cmd_q[1] : 2'bx, WR);
      chk("t3_ack_count", ack_q.size(), 1);
      chk("t3_ack_owner", (ack_q.size() > 0) ? ack_q[0] : -1, 1);

      // Back-pressure: offered command stays stable while client inputs churn.
      do_reset();
      clear_logs();
      ready_mode = 0;
      cwrite[0]  = 1'b1;
      caddr[0]   = 24'h055AA0;
      cwdata[0]  = 32'hCAFEF00D;
      creq[0]    = 1'b1;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cwrite[0] = 1'($urandom);
         caddr[0]  = AW'($urandom);
         cwdata[0] = $urandom;
         cycle();
         chk("t4_valid", mc_cmd_valid, 1);
         chk("t4_cmd", mc_cmd, WR);
         chk("t4_addr", mc_addr, 24'h055AA0);
         chk("t4_wdata", mc_wdata, 32'hCAFEF00D);
      end
      ready_mode = 1;
      done_delay = 1;
      repeat (8) cycle();
      chk("t4_ack_count", ack_q.size(), 1);
      chk("t4_accepted_addr", (addr_q.size() > 0) ? addr_q[0] : '1, 24'h055AA0);

      // Controller stalled for two refresh periods: overrun is set and sticks.
      do_reset();
      clear_logs();
      ready_mode = 0;
      cwrite[0]  = 1'b0;
      caddr[0]   = 24'h000321;
      creq[0]    = 1'b1;
      repeat (2 * P) cycle();
      chk("t5_overrun_set", refresh_overrun, 1);
      ready_mode = 1;
      done_delay = 2;
      repeat (20) cycle();
      chk("t5_overrun_sticky", refresh_overrun, 1);

      // Reset while waiting for completion: command abandoned, later done gives no ack.
      do_reset();
      clear_logs();
      ready_mode = 1;
      done_delay = 10;
      cwrite[0]  = 1'b0;
      caddr[0]   = 24'h000123;
      creq[0]    = 1'b1;
      repeat (4) cycle();
      chk("t6_in_wait", (cmd_q.size() == 1) && !mc_cmd_valid, 1);
      do_reset();
      clear_logs();
      ctl_out = 1'b1;
      ctl_cnt = 2;
      repeat (6) cycle();
      chk("t6_no_ack", ack_q.size(), 0);
      done_delay = 1;
      creq[1]    = 1'b1;
      cwrite[1]  = 1'b1;
      repeat (6) cycle();
      chk("t6_idle_after_reset", ack_q.size(), 1);

      // Randomised traffic with stalls, spurious completions and occasional resets.
      do_reset();
      clear_logs();
      ready_mode   = 2;
      done_delay   = 0;
      spurious_en  = 1'b1;
      rand_clients = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) ready_mode = 1;
         if ($urandom_range(599) == 0) do_reset();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
